// File: rtl/data_bus_responder.sv
// Memory-mapped data bus responder: word RAM, cycle counter, console byte FIFO.
// Optional cycle counter enabled by defining DATA_BUS_RESPONDER_CYCLE_CTR_EN.
module data_bus_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_write,
    output logic [31:0] data_in,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready
);

    localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [29:0] CYCLE_WADDR    = 30'h2000_0000;
    localparam logic [29:0] CON_DATA_WADDR = 30'h2000_0001;
    localparam logic [29:0] CON_STAT_WADDR = 30'h2000_0002;

    logic [29:0]   word_addr;
    logic          ram_sel;
    logic          cycle_sel;
    logic          con_data_sel;
    logic          con_stat_sel;
    logic [AW-1:0] ram_idx;
    logic          unused_addr_lsbs;

    assign word_addr        = data_addr[31:2];
    assign ram_sel          = (data_addr[31:AW+2] == '0);
    assign cycle_sel        = (word_addr == CYCLE_WADDR);
    assign con_data_sel     = (word_addr == CON_DATA_WADDR);
    assign con_stat_sel     = (word_addr == CON_STAT_WADDR);
    assign ram_idx          = data_addr[AW+1:2];
    assign unused_addr_lsbs = ^data_addr[1:0];

    // RAM has no reset; contents survive rst, but writes under rst are dropped.
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (!rst && data_write && ram_sel) begin
            ram[ram_idx] <= data_out;
        end
    end

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          ovf_set;
    logic          ovf_clr;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop      = !empty && con_ready;
    assign push_req = data_write && con_data_sel;
    // A pop in the same cycle frees a slot, so a push while full is still accepted.
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = data_write && con_stat_sel && data_out[2];

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= data_out[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign con_valid = !empty;
    assign con_data  = fifo_mem[rd_ptr];

    logic [31:0] cycle_val;

`ifdef DATA_BUS_RESPONDER_CYCLE_CTR_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    logic [4:0] stat_count;

    assign stat_count = 5'(count);

    always_comb begin
        data_in = '0;
        if (ram_sel) begin
            data_in = ram[ram_idx];
        end else if (cycle_sel) begin
            data_in = cycle_val;
        end else if (con_stat_sel) begin
            data_in = {24'h0, stat_count, overflow, empty, full};
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: queue-based reference model, randomized traffic.
module tb_data_bus_responder;

    localparam int unsigned RW = 1024;
    localparam int unsigned FD = 4;

    localparam logic [31:0] A_CYCLE    = 32'h8000_0000;
    localparam logic [31:0] A_CON_DATA = 32'h8000_0004;
    localparam logic [31:0] A_CON_STAT = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic        data_write;
    logic [31:0] data_in;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;

    always #5 clk = ~clk;

    data_bus_responder #(
        .RAM_WORDS (RW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_addr (data_addr),
        .data_out  (data_out),
        .data_write(data_write),
        .data_in   (data_in),
        .con_valid (con_valid),
        .con_data  (con_data),
        .con_ready (con_ready)
    );

    // Reference model state
    logic [31:0] m_ram   [RW];
    bit          m_known [RW];
    logic [7:0]  m_fifo  [$];
    bit          m_ovf;
    logic [31:0] m_cyc;

    // Scoreboard
    logic [31:0] rd_q  [$];
    logic [7:0]  con_q [$];
    bit          rd_chk    = 1'b0;
    bit          exp_valid = 1'b0;
    bit          done      = 1'b0;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    function automatic void model_reset();
        m_fifo.delete();
        m_ovf = 1'b0;
        m_cyc = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit chk);
        int unsigned widx;
        int unsigned sz;
        widx = a >> 2;
        sz   = m_fifo.size();
        chk  = 1'b1;
        if (widx < RW) begin
            chk = m_known[widx];
            return m_ram[widx];
        end
        if (widx == (A_CYCLE >> 2)) begin
`ifdef DATA_BUS_RESPONDER_CYCLE_CTR_EN
            return m_cyc;
`else
            return 32'h0;
`endif
        end
        if (widx == (A_CON_STAT >> 2)) begin
            return {24'h0, 5'(sz), m_ovf, (sz == 0), (sz == FD)};
        end
        return 32'h0;
    endfunction

    // Effect of the upcoming posedge on the model, given the inputs now driven.
    function automatic void model_edge(input bit w, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        int unsigned widx;
        bit          popping;
        bit          was_full;
        if (rst) return;
        widx     = a >> 2;
        popping  = (m_fifo.size() > 0) && rdy;
        was_full = (m_fifo.size() == FD);
        if (popping) con_q.push_back(m_fifo.pop_front());
        if (w) begin
            if (widx < RW) begin
                m_ram[widx]   = d;
                m_known[widx] = 1'b1;
            end else if (widx == (A_CON_DATA >> 2)) begin
                if (!was_full || popping) m_fifo.push_back(d[7:0]);
                else m_ovf = 1'b1;
            end else if (widx == (A_CON_STAT >> 2) && d[2]) begin
                m_ovf = 1'b0;
            end
        end
        m_cyc = m_cyc + 32'd1;
    endfunction

    task automatic step(input bit w, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        logic [31:0] exp;
        bit          chk;
        data_write = w;
        data_addr  = a;
        data_out   = d;
        con_ready  = rdy;
        exp        = model_read(a, chk);
        if (chk) rd_q.push_back(exp);
        rd_chk    = chk;
        exp_valid = (m_fifo.size() != 0);
        model_edge(w, a, d, rdy);
        @(posedge clk);
        #1;
    endtask

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_chk) begin
                if (rd_q.size() == 0) check("rd_queue_underrun", 32'h1, 32'h0);
                else check("data_in", data_in, rd_q.pop_front());
            end
            check("con_valid", {31'h0, con_valid}, {31'h0, exp_valid});
            if (con_valid && con_ready) begin
                if (con_q.size() == 0) check("unexpected_pop", {24'h0, con_data}, 32'hFFFF_FFFF);
                else check("con_data", {24'h0, con_data}, {24'h0, con_q.pop_front()});
            end
            if (done) begin
                check("con_q_drained", con_q.size(), 32'h0);
                check("rd_q_drained", rd_q.size(), 32'h0);
                $display("%0d/%0d checks passed", n_pass, n_total);
                $finish;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int unsigned r;
        int unsigned thresh;
        rst        = 1'b1;
        data_write = 1'b0;
        data_addr  = '0;
        data_out   = '0;
        con_ready  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step(1'b1, A_CON_DATA, 32'h99, 1'b0);
        step(1'b1, A_CON_STAT, 32'h0, 1'b1);
        rst = 1'b0;
        step(1'b0, A_CON_STAT, 32'h0, 1'b0);
        step(1'b0, A_CYCLE, 32'h0, 1'b0);
        step(1'b0, 32'h4000_0000, 32'h0, 1'b0);

        // RAM write/read with old-value same-cycle read and byte-offset aliasing
        step(1'b1, 32'h10, 32'h1111_1111, 1'b0);
        step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 32'h10, 32'h0, 1'b0);
        step(1'b0, 32'h13, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0);
        step(1'b1, 32'h0000_1000, 32'h0BAD_0BAD, 1'b0);
        step(1'b0, 32'h0000_0FFC, 32'h0, 1'b0);
        step(1'b0, 32'h0000_1000, 32'h0, 1'b0);

        // Overfill with sink stalled, then drain
        for (int i = 0; i < 5; i++) step(1'b1, A_CON_DATA, 32'h41 + i, 1'b0);
        step(1'b0, A_CON_STAT, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, A_CON_STAT, 32'h0, 1'b1);
        step(1'b0, A_CON_DATA, 32'h0, 1'b0);

        // Sticky overflow: W1C on bit 2 only
        step(1'b1, A_CON_STAT, 32'hFFFF_FFFB, 1'b0);
        step(1'b0, A_CON_STAT, 32'h0, 1'b0);
        step(1'b1, A_CON_STAT, 32'h4, 1'b0);
        step(1'b0, A_CON_STAT, 32'h0, 1'b0);

        // Push into full FIFO coinciding with a pop
        for (int i = 0; i < 4; i++) step(1'b1, A_CON_DATA, 32'h61 + i, 1'b0);
        step(1'b1, A_CON_DATA, 32'h55, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, A_CON_STAT, 32'h0, 1'b1);

        // Cycle counter sampled N and N+5 cycles apart
        step(1'b0, A_CYCLE, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, A_CYCLE, 32'h1234, 1'b0);
        step(1'b0, A_CYCLE, 32'h0, 1'b0);

        // Asynchronous reset mid-cycle with bytes queued; RAM must survive
        for (int i = 0; i < 3; i++) step(1'b1, A_CON_DATA, 32'h70 + i, 1'b0);
        rst = 1'b1;
        model_reset();
        step(1'b0, A_CON_STAT, 32'h0, 1'b1);
        step(1'b0, A_CYCLE, 32'h0, 1'b1);
        rst = 1'b0;
        step(1'b0, 32'h10, 32'h0, 1'b1);
        step(1'b0, A_CON_STAT, 32'h0, 1'b1);

        // Randomized traffic
        thresh = 30;
        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 0) thresh = (thresh == 30) ? 85 : 30;
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                model_reset();
                step(1'b1, A_CON_DATA, $urandom, 1'b1);
                rst = 1'b0;
            end
            r = $urandom_range(0, 9);
            d = $urandom;
            case (r)
                0, 1, 2, 3: begin
                    a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15))
                                                    : 32'($urandom_range(RW - 16, RW - 1));
                    a = (a << 2) | 32'($urandom_range(0, 3));
                end
                4:       a = A_CYCLE | 32'($urandom_range(0, 3));
                5, 6:    a = A_CON_DATA | 32'($urandom_range(0, 3));
                7:       a = A_CON_STAT | 32'($urandom_range(0, 3));
                default: begin
                    case ($urandom_range(0, 3))
                        0:       a = 32'h8000_000C;
                        1:       a = 32'h4000_0000;
                        2:       a = 32'(RW * 4);
                        default: a = 32'hFFFF_FFFC;
                    endcase
                end
            endcase
            step($urandom_range(0, 1) != 0, a, d, $urandom_range(0, 99) < thresh);
        end

        for (int i = 0; i < FD + 4; i++) step(1'b0, A_CON_STAT, 32'h0, 1'b1);
        data_write = 1'b0;
        con_ready  = 1'b0;
        rd_chk     = 1'b0;
        exp_valid  = (m_fifo.size() != 0);
        done       = 1'b1;
    end

endmodule
